// File: rtl/legv8_main_ctrl.sv
// ---------------------------------------------------------------------------
// legv8_main_ctrl
//
// Multicycle main control unit for the LEGv8 core. Each instruction is
// sequenced through fetch, decode, execute, memory and write-back states.
// The unit drives every datapath enable and mux select, and it produces the
// ALU_OP code that alu_ctrl combines with OPCODE to pick the ALU function.
// Instruction and data memory use a ready handshake, so the sequencer holds
// in FETCH, LOAD_MEM or STORE_MEM until MEM_READY is seen.
//
// Ports
//    CLK            in   rising-edge clock
//    RST            in   synchronous, active-high reset
//    OPCODE[10:0]   in   IR[31:21], stable from DECODE onward
//    MEM_READY      in   memory finishes the current access this cycle
//    ALU_OP[1:0]    out  00 ADD, 01 PASS B, 10 R-type function
//    ALU_SRC_A      out  0 = PC, 1 = register A
//    ALU_SRC_B[1:0] out  00 reg B, 01 const 4, 10 sext imm, 11 branch off<<2
//    PC_SRC         out  0 = ALU result, 1 = ALUOut register
//    PC_WRITE       out  unconditional PC load
//    PC_WRITE_COND  out  PC load gated by the datapath zero flag
//    IR_WRITE       out  instruction register load
//    MEM_READ       out  memory read request
//    MEM_WRITE      out  memory write request
//    I_OR_D         out  memory address: 0 = PC, 1 = ALUOut
//    REG2_LOC       out  second read port: 1 = Rt, 0 = Rm
//    REG_WRITE      out  register file write enable
//    MEM_TO_REG     out  write-back data: 1 = MDR, 0 = ALUOut
//    RETIRE         out  one-cycle pulse in the last cycle of an instruction
//    ILLEGAL        out  sticky flag, set when an undecodable opcode is seen
// ---------------------------------------------------------------------------
module legv8_main_ctrl (
   input  logic        CLK,
   input  logic        RST,
   input  logic [10:0] OPCODE,
   input  logic        MEM_READY,
   output logic [1:0]  ALU_OP,
   output logic        ALU_SRC_A,
   output logic [1:0]  ALU_SRC_B,
   output logic        PC_SRC,
   output logic        PC_WRITE,
   output logic        PC_WRITE_COND,
   output logic        IR_WRITE,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic        I_OR_D,
   output logic        REG2_LOC,
   output logic        REG_WRITE,
   output logic        MEM_TO_REG,
   output logic        RETIRE,
   output logic        ILLEGAL
);

   // Fixed LEGv8 opcode encodings for the supported instruction subset.
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [5:0]  OP_B    = 6'b000101;

   // ALU_OP codes understood by alu_ctrl.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   // ALU B-operand mux selects.
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BROFF  = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_R_WB,
      S_ADDR,
      S_LOAD_MEM,
      S_LOAD_WB,
      S_STORE_MEM,
      S_CBZ_EXEC,
      S_B_EXEC,
      S_HALT
   } state_t;

   state_t state;
   logic   illegal_q;
   logic   is_load_q;

   logic   is_rtype;
   logic   is_ldur;
   logic   is_stur;
   logic   is_cbz;
   logic   is_b;
   logic   reg2_dec;

   // Opcode classification. CBZ and B match only on their upper bits because
   // the remaining bits of IR[31:21] belong to their offset fields.
   always_comb begin
      is_rtype = (OPCODE == OP_ADD) || (OPCODE == OP_SUB) ||
                 (OPCODE == OP_AND) || (OPCODE == OP_ORR);
      is_ldur  = (OPCODE == OP_LDUR);
      is_stur  = (OPCODE == OP_STUR);
      is_cbz   = (OPCODE[10:3] == OP_CBZ);
      is_b     = (OPCODE[10:5] == OP_B);
      reg2_dec = is_stur || is_cbz;
   end

   // State register plus the two flags captured alongside it. The load/store
   // choice is latched in DECODE so ADDR does not have to look at OPCODE
   // again; ILLEGAL is set on the DECODE-to-HALT transition and only reset
   // can clear it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_FETCH;
         illegal_q <= 1'b0;
         is_load_q <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (MEM_READY) state <= S_DECODE;
            end
            S_DECODE: begin
               is_load_q <= is_ldur;
               if (is_rtype) begin
                  state <= S_EXEC_R;
               end else if (is_ldur || is_stur) begin
                  state <= S_ADDR;
               end else if (is_cbz) begin
                  state <= S_CBZ_EXEC;
               end else if (is_b) begin
                  state <= S_B_EXEC;
               end else begin
                  state     <= S_HALT;
                  illegal_q <= 1'b1;
               end
            end
            S_EXEC_R:    state <= S_R_WB;
            S_R_WB:      state <= S_FETCH;
            S_ADDR:      state <= is_load_q ? S_LOAD_MEM : S_STORE_MEM;
            S_LOAD_MEM: begin
               if (MEM_READY) state <= S_LOAD_WB;
            end
            S_LOAD_WB:   state <= S_FETCH;
            S_STORE_MEM: begin
               if (MEM_READY) state <= S_FETCH;
            end
            S_CBZ_EXEC:  state <= S_FETCH;
            S_B_EXEC:    state <= S_FETCH;
            S_HALT:      state <= S_HALT;
            default:     state <= S_FETCH;
         endcase
      end
   end

   // Output decode from the registered state. Only IR_WRITE/PC_WRITE in
   // FETCH and RETIRE in STORE_MEM look at MEM_READY, so an access request
   // stays steady across a stall. Reset overrides everything last so the
   // datapath sees no enables while the sequencer is being reset.
   always_comb begin
      ALU_OP        = ALUOP_ADD;
      ALU_SRC_A     = 1'b0;
      ALU_SRC_B     = SRCB_REG;
      PC_SRC        = 1'b0;
      PC_WRITE      = 1'b0;
      PC_WRITE_COND = 1'b0;
      IR_WRITE      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      I_OR_D        = 1'b0;
      REG2_LOC      = 1'b0;
      REG_WRITE     = 1'b0;
      MEM_TO_REG    = 1'b0;
      RETIRE        = 1'b0;
      ILLEGAL       = illegal_q;

      case (state)
         S_FETCH: begin
            MEM_READ  = 1'b1;
            ALU_SRC_B = SRCB_FOUR;
            IR_WRITE  = MEM_READY;
            PC_WRITE  = MEM_READY;
         end
         S_DECODE: begin
            ALU_SRC_B = SRCB_BROFF;
         end
         S_EXEC_R: begin
            ALU_SRC_A = 1'b1;
            ALU_OP    = ALUOP_RTYPE;
         end
         S_R_WB: begin
            REG_WRITE = 1'b1;
            RETIRE    = 1'b1;
         end
         S_ADDR: begin
            ALU_SRC_A = 1'b1;
            ALU_SRC_B = SRCB_IMM;
         end
         S_LOAD_MEM: begin
            MEM_READ = 1'b1;
            I_OR_D   = 1'b1;
         end
         S_LOAD_WB: begin
            REG_WRITE  = 1'b1;
            MEM_TO_REG = 1'b1;
            RETIRE     = 1'b1;
         end
         S_STORE_MEM: begin
            MEM_WRITE = 1'b1;
            I_OR_D    = 1'b1;
            RETIRE    = MEM_READY;
         end
         S_CBZ_EXEC: begin
            ALU_SRC_A     = 1'b1;
            ALU_OP        = ALUOP_PASSB;
            PC_WRITE_COND = 1'b1;
            PC_SRC        = 1'b1;
            RETIRE        = 1'b1;
         end
         S_B_EXEC: begin
            PC_WRITE = 1'b1;
            PC_SRC   = 1'b1;
            RETIRE   = 1'b1;
         end
         default: begin
         end
      endcase

      // REG2_LOC is a pure opcode decode, but FETCH has no valid IR yet and
      // HALT keeps every output except ILLEGAL quiet.
      if ((state != S_FETCH) && (state != S_HALT)) begin
         REG2_LOC = reg2_dec;
      end

      if (RST) begin
         ALU_OP        = 2'b00;
         ALU_SRC_A     = 1'b0;
         ALU_SRC_B     = 2'b00;
         PC_SRC        = 1'b0;
         PC_WRITE      = 1'b0;
         PC_WRITE_COND = 1'b0;
         IR_WRITE      = 1'b0;
         MEM_READ      = 1'b0;
         MEM_WRITE     = 1'b0;
         I_OR_D        = 1'b0;
         REG2_LOC      = 1'b0;
         REG_WRITE     = 1'b0;
         MEM_TO_REG    = 1'b0;
         RETIRE        = 1'b0;
         ILLEGAL       = 1'b0;
      end
   end

endmodule

// File: tb/tb_legv8_main_ctrl.sv
// ---------------------------------------------------------------------------
// tb_legv8_main_ctrl
//
// Directed bench for the LEGv8 multicycle main control unit. Every cycle the
// outputs are packed into one 17-bit word and compared with a hand-written
// expected word for the state the sequencer should be in.
//
// Packed word layout:
//    [16:15] ALU_OP  [14] ALU_SRC_A  [13:12] ALU_SRC_B  [11] PC_SRC
//    [10] PC_WRITE   [9] PC_WRITE_COND  [8] IR_WRITE  [7] MEM_READ
//    [6] MEM_WRITE   [5] I_OR_D  [4] REG2_LOC  [3] REG_WRITE
//    [2] MEM_TO_REG  [1] RETIRE  [0] ILLEGAL
// ---------------------------------------------------------------------------
module tb_legv8_main_ctrl;

   logic        CLK;
   logic        RST;
   logic [10:0] OPCODE;
   logic        MEM_READY;
   logic [1:0]  ALU_OP;
   logic        ALU_SRC_A;
   logic [1:0]  ALU_SRC_B;
   logic        PC_SRC;
   logic        PC_WRITE;
   logic        PC_WRITE_COND;
   logic        IR_WRITE;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic        I_OR_D;
   logic        REG2_LOC;
   logic        REG_WRITE;
   logic        MEM_TO_REG;
   logic        RETIRE;
   logic        ILLEGAL;

   int checks;
   int errors;

   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [10:0] OPC_CBZ  = 11'b10110100101;
   localparam logic [10:0] OPC_B    = 11'b00010100000;
   localparam logic [10:0] OPC_BAD  = 11'b11111111111;

   // Hand-derived expected output words, one per state/condition.
   //                                     aop a  b  ps pw pc ir mr mw id r2 rw mt rt il
   localparam logic [16:0] E_ZERO     = 17'b00_0_00_0_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [16:0] E_FETCH_W  = 17'b00_0_01_0_0_0_0_1_0_0_0_0_0_0_0;
   localparam logic [16:0] E_FETCH_R  = 17'b00_0_01_0_1_0_1_1_0_0_0_0_0_0_0;
   localparam logic [16:0] E_DEC_R0   = 17'b00_0_11_0_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [16:0] E_DEC_R1   = 17'b00_0_11_0_0_0_0_0_0_0_1_0_0_0_0;
   localparam logic [16:0] E_EXEC_R   = 17'b10_1_00_0_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [16:0] E_R_WB     = 17'b00_0_00_0_0_0_0_0_0_0_0_1_0_1_0;
   localparam logic [16:0] E_ADDR_LD  = 17'b00_1_10_0_0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [16:0] E_ADDR_ST  = 17'b00_1_10_0_0_0_0_0_0_0_1_0_0_0_0;
   localparam logic [16:0] E_LOADMEM  = 17'b00_0_00_0_0_0_0_1_0_1_0_0_0_0_0;
   localparam logic [16:0] E_LOAD_WB  = 17'b00_0_00_0_0_0_0_0_0_0_0_1_1_1_0;
   localparam logic [16:0] E_STORE_W  = 17'b00_0_00_0_0_0_0_0_1_1_1_0_0_0_0;
   localparam logic [16:0] E_STORE_R  = 17'b00_0_00_0_0_0_0_0_1_1_1_0_0_1_0;
   localparam logic [16:0] E_CBZ_EX   = 17'b01_1_00_1_0_1_0_0_0_0_1_0_0_1_0;
   localparam logic [16:0] E_B_EX     = 17'b00_0_00_1_1_0_0_0_0_0_0_0_0_1_0;
   localparam logic [16:0] E_HALT     = 17'b00_0_00_0_0_0_0_0_0_0_0_0_0_0_1;

   legv8_main_ctrl dut (
      .CLK           (CLK),
      .RST           (RST),
      .OPCODE        (OPCODE),
      .MEM_READY     (MEM_READY),
      .ALU_OP        (ALU_OP),
      .ALU_SRC_A     (ALU_SRC_A),
      .ALU_SRC_B     (ALU_SRC_B),
      .PC_SRC        (PC_SRC),
      .PC_WRITE      (PC_WRITE),
      .PC_WRITE_COND (PC_WRITE_COND),
      .IR_WRITE      (IR_WRITE),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .I_OR_D        (I_OR_D),
      .REG2_LOC      (REG2_LOC),
      .REG_WRITE     (REG_WRITE),
      .MEM_TO_REG    (MEM_TO_REG),
      .RETIRE        (RETIRE),
      .ILLEGAL       (ILLEGAL)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [16:0] packOutputs();
      return {ALU_OP, ALU_SRC_A, ALU_SRC_B, PC_SRC, PC_WRITE, PC_WRITE_COND,
              IR_WRITE, MEM_READ, MEM_WRITE, I_OR_D, REG2_LOC, REG_WRITE,
              MEM_TO_REG, RETIRE, ILLEGAL};
   endfunction

   task automatic applyStimulus(input logic rst, input logic rdy,
                                input logic [10:0] op);
      RST       = rst;
      MEM_READY = rdy;
      OPCODE    = op;
   endtask

   task automatic checkOutput(input string tag, input logic [16:0] observed,
                              input logic [16:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs just after the rising edge, let the
   // combinational outputs settle, compare, then advance to the next edge.
   task automatic runCycle(input string tag, input logic rst, input logic rdy,
                           input logic [10:0] op, input logic [16:0] expected);
      applyStimulus(rst, rdy, op);
      #2;
      checkOutput(tag, packOutputs(), expected);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      applyStimulus(1'b1, 1'b0, OPC_ADD);
      @(posedge CLK);
      #1;

      // Initial reset: outputs quiet while RST is high.
      runCycle("rst_a", 1'b1, 1'b1, OPC_ADD, E_ZERO);
      runCycle("rst_b", 1'b1, 1'b1, OPC_ADD, E_ZERO);

      // ADD with zero-wait memory; MEM_READY held high outside FETCH to show
      // it is ignored there.
      runCycle("add_fetch",  1'b0, 1'b1, OPC_ADD, E_FETCH_R);
      runCycle("add_decode", 1'b0, 1'b1, OPC_ADD, E_DEC_R0);
      runCycle("add_exec",   1'b0, 1'b1, OPC_ADD, E_EXEC_R);
      runCycle("add_wb",     1'b0, 1'b1, OPC_ADD, E_R_WB);

      // LDUR: two wait cycles in FETCH, three in LOAD_MEM.
      runCycle("ld_fetch_w0", 1'b0, 1'b0, OPC_LDUR, E_FETCH_W);
      runCycle("ld_fetch_w1", 1'b0, 1'b0, OPC_LDUR, E_FETCH_W);
      runCycle("ld_fetch_r",  1'b0, 1'b1, OPC_LDUR, E_FETCH_R);
      runCycle("ld_decode",   1'b0, 1'b0, OPC_LDUR, E_DEC_R0);
      runCycle("ld_addr",     1'b0, 1'b0, OPC_LDUR, E_ADDR_LD);
      for (int i = 0; i < 3; i++) begin
         runCycle($sformatf("ld_mem_w%0d", i), 1'b0, 1'b0, OPC_LDUR, E_LOADMEM);
      end
      runCycle("ld_mem_r",    1'b0, 1'b1, OPC_LDUR, E_LOADMEM);
      runCycle("ld_wb",       1'b0, 1'b0, OPC_LDUR, E_LOAD_WB);

      // STUR with two wait cycles in STORE_MEM.
      runCycle("st_fetch",   1'b0, 1'b1, OPC_STUR, E_FETCH_R);
      runCycle("st_decode",  1'b0, 1'b0, OPC_STUR, E_DEC_R1);
      runCycle("st_addr",    1'b0, 1'b0, OPC_STUR, E_ADDR_ST);
      runCycle("st_mem_w0",  1'b0, 1'b0, OPC_STUR, E_STORE_W);
      runCycle("st_mem_w1",  1'b0, 1'b0, OPC_STUR, E_STORE_W);
      runCycle("st_mem_r",   1'b0, 1'b1, OPC_STUR, E_STORE_R);

      // CBZ followed by B, three cycles each.
      runCycle("cbz_fetch",  1'b0, 1'b1, OPC_CBZ, E_FETCH_R);
      runCycle("cbz_decode", 1'b0, 1'b0, OPC_CBZ, E_DEC_R1);
      runCycle("cbz_exec",   1'b0, 1'b0, OPC_CBZ, E_CBZ_EX);
      runCycle("b_fetch",    1'b0, 1'b1, OPC_B,   E_FETCH_R);
      runCycle("b_decode",   1'b0, 1'b0, OPC_B,   E_DEC_R0);
      runCycle("b_exec",     1'b0, 1'b0, OPC_B,   E_B_EX);

      // Reset asserted for two cycles in the middle of a LOAD_MEM stall.
      runCycle("rl_fetch",   1'b0, 1'b1, OPC_LDUR, E_FETCH_R);
      runCycle("rl_decode",  1'b0, 1'b0, OPC_LDUR, E_DEC_R0);
      runCycle("rl_addr",    1'b0, 1'b0, OPC_LDUR, E_ADDR_LD);
      runCycle("rl_mem_w",   1'b0, 1'b0, OPC_LDUR, E_LOADMEM);
      runCycle("rl_rst0",    1'b1, 1'b1, OPC_LDUR, E_ZERO);
      runCycle("rl_rst1",    1'b1, 1'b1, OPC_LDUR, E_ZERO);
      runCycle("rl_after",   1'b0, 1'b0, OPC_LDUR, E_FETCH_W);
      runCycle("rl_fetch2",  1'b0, 1'b1, OPC_B,    E_FETCH_R);
      runCycle("rl_decode2", 1'b0, 1'b0, OPC_B,    E_DEC_R0);
      runCycle("rl_bexec",   1'b0, 1'b0, OPC_B,    E_B_EX);

      // Illegal opcode: HALT for 20 cycles whatever MEM_READY does.
      runCycle("ill_fetch",  1'b0, 1'b1, OPC_BAD, E_FETCH_R);
      runCycle("ill_decode", 1'b0, 1'b0, OPC_BAD, E_DEC_R0);
      for (int i = 0; i < 20; i++) begin
         runCycle($sformatf("ill_halt%0d", i), 1'b0, i[0], OPC_BAD, E_HALT);
      end
      runCycle("ill_rst",    1'b1, 1'b1, OPC_ADD, E_ZERO);
      runCycle("ill_fetch2", 1'b0, 1'b1, OPC_ADD, E_FETCH_R);
      runCycle("ill_decode2",1'b0, 1'b0, OPC_ADD, E_DEC_R0);
      runCycle("ill_exec2",  1'b0, 1'b0, OPC_ADD, E_EXEC_R);
      runCycle("ill_wb2",    1'b0, 1'b0, OPC_ADD, E_R_WB);
      runCycle("ill_next",   1'b0, 1'b0, OPC_ADD, E_FETCH_W);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
